// File: rtl/cpu_bus_if_pkg.sv
// cpu_bus_if_pkg: constants shared by the bus interface unit, its bus
// interface bundle and the watchdog sub-module.
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - READ/WRITE direction levels, ENABLE_/DISABLE_ active-low levels
//   - default widths derived from the CPU word-address width
package cpu_bus_if_pkg;

  localparam int CPU_WORD_ADDR_W = 30;
  localparam int CPU_DATA_W      = 32;
  localparam int SPM_WORD_ADDR_W = 12;
  localparam int BUS_IF_STATE_W  = 2;

  localparam logic [BUS_IF_STATE_W-1:0] BUS_IF_STATE_IDLE   = 2'd0;
  localparam logic [BUS_IF_STATE_W-1:0] BUS_IF_STATE_REQ    = 2'd1;
  localparam logic [BUS_IF_STATE_W-1:0] BUS_IF_STATE_ACCESS = 2'd2;
  localparam logic [BUS_IF_STATE_W-1:0] BUS_IF_STATE_STALL  = 2'd3;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // States in which the unit owns (or is asking for) the system bus.
  function automatic logic is_bus_phase(input logic [BUS_IF_STATE_W-1:0] st);
    return (st == BUS_IF_STATE_REQ) || (st == BUS_IF_STATE_ACCESS);
  endfunction

  function automatic logic is_read(input logic rw);
    return rw != WRITE;
  endfunction

endpackage

// File: rtl/cpu_bus_if_if.sv
// cpu_bus_if_if: system-bus handshake bundle (req/grnt/as/rdy, all
// active-low) plus address, direction and data.
//   master : the bus interface unit (drives request, strobe, address, data)
//   slave  : the bus/arbiter side (drives grant, ready, read data)
interface cpu_bus_if_if
  import cpu_bus_if_pkg::*;
#(
  parameter int ADDR_W = CPU_WORD_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);

  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rdy_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rdy_, bus_rd_data
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rdy_, bus_rd_data
  );

endinterface

// File: rtl/cpu_bus_if_timeout.sv
// cpu_bus_if_timeout: access watchdog counter with terminal-count compare.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clears the counter (access launch)
//   en         : count this cycle (unit is in REQ or ACCESS)
//   tc         : counter has reached TIMEOUT-1; never asserted when TIMEOUT==0
module cpu_bus_if_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tcnt_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_p0 <= '0;
    end else if (clr) begin
      tcnt_p0 <= '0;
    end else if (en && (TIMEOUT != 0)) begin
      tcnt_p0 <= tcnt_p0 + 1'b1;
    end
  end

  assign tc = (TIMEOUT != 0) && (tcnt_p0 == TC_VAL);

endmodule

// File: rtl/cpu_bus_if.sv
// cpu_bus_if: bus interface unit of one pipeline stage (IF or MEM).
// Accesses inside the SPM window go to the scratch-pad combinationally;
// everything else runs a req/grnt/as/rdy cycle on the system bus.
//   clk, reset      : clock, asynchronous active-high reset
//   stall, flush    : owning-stage pipeline controls
//   busy            : access in progress, owning stage must stall
//   addr/as_/rw/wr_data/rd_data : stage-side access port
//   bus_err         : one-cycle pulse after a watchdog abort
//   spm_*           : scratch-pad memory port
//   bus             : system bus (master modport)
module cpu_bus_if
  import cpu_bus_if_pkg::*;
#(
  parameter int          ADDR_W     = CPU_WORD_ADDR_W,
  parameter int          DATA_W     = CPU_DATA_W,
  parameter int          SPM_ADDR_W = SPM_WORD_ADDR_W,
  parameter int unsigned SPM_BASE   = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  bus_err,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  cpu_bus_if_if.master          bus
);

  localparam int TAG_W = ADDR_W - SPM_ADDR_W;
  localparam logic [TAG_W-1:0] SPM_TAG = TAG_W'(SPM_BASE);

  logic [BUS_IF_STATE_W-1:0] state_p0;
  logic                      req_p0;
  logic                      as_p0;
  logic                      rw_p0;
  logic [ADDR_W-1:0]         addr_p0;
  logic [DATA_W-1:0]         wdata_p0;
  logic [DATA_W-1:0]         rd_buf_p0;
  logic                      err_p0;
  logic                      discard_p0;

  logic                      spm_hit;
  logic                      in_idle;
  logic                      in_req;
  logic                      in_access;
  logic                      spm_sel;
  logic                      launch;
  logic                      done;
  logic                      abort;
  logic                      fwd;
  logic                      tmo_tc;
  logic [BUS_IF_STATE_W-1:0] end_state;

  assign spm_hit   = (addr[ADDR_W-1:SPM_ADDR_W] == SPM_TAG);
  assign in_idle   = (state_p0 == BUS_IF_STATE_IDLE);
  assign in_req    = (state_p0 == BUS_IF_STATE_REQ);
  assign in_access = (state_p0 == BUS_IF_STATE_ACCESS);

  assign spm_sel = in_idle && (as_ == ENABLE_) && spm_hit  && !flush;
  assign launch  = in_idle && (as_ == ENABLE_) && !spm_hit && !flush;
  assign done    = in_access && (bus.bus_rdy_ == ENABLE_);
  // A flush before grant retires the request quietly; ready always beats the watchdog.
  assign abort   = ((in_req && !flush) || in_access) && tmo_tc && !done;
  // Read data of a flushed access is never forwarded nor buffered.
  assign fwd     = done && is_read(rw_p0) && !flush && !discard_p0;
  assign end_state = (stall && !flush && !discard_p0) ? BUS_IF_STATE_STALL
                                                      : BUS_IF_STATE_IDLE;

  cpu_bus_if_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (is_bus_phase(state_p0)),
    .tc    (tmo_tc)
  );

  // Stage side: combinational SPM path and busy/read-data steering
  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_as_     = spm_sel ? ENABLE_ : DISABLE_;

  always_comb begin
    busy = launch || (in_req && !abort) || (in_access && !done && !abort);
    if (spm_sel) begin
      rd_data = spm_rd_data;
    end else if (fwd) begin
      rd_data = bus.bus_rd_data;
    end else begin
      rd_data = rd_buf_p0;
    end
  end

  // p0: bus FSM, latched bus request and read hold buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0   <= BUS_IF_STATE_IDLE;
      req_p0     <= DISABLE_;
      as_p0      <= DISABLE_;
      rw_p0      <= READ;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      rd_buf_p0  <= '0;
      err_p0     <= 1'b0;
      discard_p0 <= 1'b0;
    end else begin
      err_p0 <= 1'b0;
      case (state_p0)
        BUS_IF_STATE_IDLE: begin
          if (launch) begin
            req_p0     <= ENABLE_;
            rw_p0      <= rw;
            addr_p0    <= addr;
            wdata_p0   <= wr_data;
            discard_p0 <= 1'b0;
            state_p0   <= BUS_IF_STATE_REQ;
          end
        end
        BUS_IF_STATE_REQ: begin
          if (flush) begin
            req_p0   <= DISABLE_;
            state_p0 <= BUS_IF_STATE_IDLE;
          end else if (abort) begin
            req_p0    <= DISABLE_;
            rd_buf_p0 <= '0;
            err_p0    <= 1'b1;
            state_p0  <= end_state;
          end else if (bus.bus_grnt_ == ENABLE_) begin
            as_p0    <= ENABLE_;
            state_p0 <= BUS_IF_STATE_ACCESS;
          end
        end
        BUS_IF_STATE_ACCESS: begin
          // The strobe is a single-cycle pulse on entry to ACCESS.
          as_p0 <= DISABLE_;
          if (flush) begin
            discard_p0 <= 1'b1;
          end
          if (done) begin
            req_p0   <= DISABLE_;
            state_p0 <= end_state;
            if (fwd) begin
              rd_buf_p0 <= bus.bus_rd_data;
            end
          end else if (abort) begin
            req_p0    <= DISABLE_;
            rd_buf_p0 <= '0;
            err_p0    <= 1'b1;
            state_p0  <= end_state;
          end
        end
        BUS_IF_STATE_STALL: begin
          if (!stall || flush) begin
            state_p0 <= BUS_IF_STATE_IDLE;
          end
        end
        default: state_p0 <= BUS_IF_STATE_IDLE;
      endcase
    end
  end

  assign bus.bus_req_    = req_p0;
  assign bus.bus_as_     = as_p0;
  assign bus.bus_rw      = rw_p0;
  assign bus.bus_addr    = addr_p0;
  assign bus.bus_wr_data = wdata_p0;
  assign bus_err         = err_p0;

endmodule

// File: tb/tb_cpu_bus_if.sv
// tb_cpu_bus_if: directed bench for cpu_bus_if (SPM_BASE=0, TIMEOUT=8).
// Stimulus pushes the expected stage-side response into a queue; a monitor
// pops and compares whenever the DUT completes an access (as_ low with busy
// low) or raises bus_err.
module tb_cpu_bus_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        bus_err;
  logic [31:0] spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;

  cpu_bus_if_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  cpu_bus_if #(
    .ADDR_W     (30),
    .DATA_W     (32),
    .SPM_ADDR_W (12),
    .SPM_BASE   (0),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .busy        (busy),
    .addr        (addr),
    .as_         (as_),
    .rw          (rw),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .bus_err     (bus_err),
    .spm_rd_data (spm_rd_data),
    .spm_addr    (spm_addr),
    .spm_as_     (spm_as_),
    .spm_rw      (spm_rw),
    .spm_wr_data (spm_wr_data),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    logic        err;
    logic        req_;
    logic        spm_as_;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   as_low_cnt = 0;
  int   err_cnt = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic expect_ev(input logic [31:0] r, input bit c, input logic e,
                           input logic rq, input logic sa);
    exp_q.push_back('{r, c, e, rq, sa});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: compare the stage-side response whenever the DUT presents one.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && ((as_ === 1'b0 && busy === 1'b0) || bus_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk32("mon_unexpected_event_queue_depth", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (e.chk_rd) chk32("mon_rd_data", rd_data, e.rd);
        chk1("mon_bus_err", bus_err, e.err);
        chk1("mon_bus_req_", bus.bus_req_, e.req_);
        chk1("mon_spm_as_", spm_as_, e.spm_as_);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.bus_as_ === 1'b0) as_low_cnt++;
    if (bus_err === 1'b1) err_cnt++;
  end

  // One full bus transaction: g REQ cycles without grant, then grant,
  // w ACCESS cycles without ready, then ready with read data rd.
  task automatic bus_xfer(input logic [29:0] a, input logic r, input logic [31:0] wd,
                          input logic [31:0] rd, input int g, input int w, input logic stl);
    as_ = 1'b0; addr = a; rw = r; wr_data = wd;
    sample();
    chk1("xfer_launch_busy", busy, 1'b1);
    next_cycle();
    for (int i = 0; i < g; i++) begin
      sample();
      chk1("xfer_req_busy", busy, 1'b1);
      chk1("xfer_req_low", bus.bus_req_, 1'b0);
      chk1("xfer_no_strobe_before_grant", bus.bus_as_, 1'b1);
      next_cycle();
    end
    bus.bus_grnt_ = 1'b0;
    sample();
    chk32("xfer_bus_addr", {2'b00, bus.bus_addr}, {2'b00, a});
    chk1("xfer_bus_rw", bus.bus_rw, r);
    next_cycle();
    bus.bus_grnt_ = 1'b1;
    for (int i = 0; i < w; i++) begin
      sample();
      chk1("xfer_access_busy", busy, 1'b1);
      chk1("xfer_bus_as_", bus.bus_as_, (i == 0) ? 1'b0 : 1'b1);
      chk32("xfer_wr_data_hold", bus.bus_wr_data, wd);
      next_cycle();
    end
    bus.bus_rdy_ = 1'b0; bus.bus_rd_data = rd; stall = stl;
    expect_ev(rd, r, 1'b0, 1'b0, 1'b1);
    sample();
    next_cycle();
    bus.bus_rdy_ = 1'b1; bus.bus_rd_data = 32'h0; as_ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int a0;
    int e0;
    reset = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    stall = 1'b0; flush = 1'b0; spm_rd_data = '0;
    bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = '0;

    // Reset values
    repeat (2) sample();
    chk1("rst_bus_req_", bus.bus_req_, 1'b1);
    chk1("rst_bus_as_", bus.bus_as_, 1'b1);
    chk1("rst_bus_rw", bus.bus_rw, 1'b1);
    chk32("rst_bus_addr", {2'b00, bus.bus_addr}, 32'h0);
    chk32("rst_bus_wr_data", bus.bus_wr_data, 32'h0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk32("rst_rd_data", rd_data, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // SPM read, zero latency
    as_ = 1'b0; addr = 30'h10; rw = 1'b1; spm_rd_data = 32'hCAFEF00D;
    expect_ev(32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0);
    sample();
    chk32("spm_addr", {20'h0, spm_addr}, 32'h010);
    chk1("spm_rw_read", spm_rw, 1'b1);
    next_cycle();

    // SPM write at the top of the window
    addr = 30'hFFF; rw = 1'b0; wr_data = 32'hA5A50001;
    expect_ev(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    chk32("spm_addr_top", {20'h0, spm_addr}, 32'hFFF);
    chk32("spm_wr_data", spm_wr_data, 32'hA5A50001);
    chk1("spm_rw_write", spm_rw, 1'b0);
    next_cycle();

    // SPM hit while flushed: no strobe
    addr = 30'h20; rw = 1'b1; flush = 1'b1;
    expect_ev(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    sample();
    next_cycle();
    flush = 1'b0; as_ = 1'b1;

    // Bus read, then a back-to-back bus write
    a0 = as_low_cnt;
    bus_xfer(30'h10000004, 1'b1, 32'h0, 32'hDEADBEEF, 2, 2, 1'b0);
    chk32("rd_strobe_pulses", as_low_cnt - a0, 32'd1);
    a0 = as_low_cnt;
    bus_xfer(30'h20000008, 1'b0, 32'h12345678, 32'h0BAD0BAD, 0, 2, 1'b0);
    chk32("wr_strobe_pulses", as_low_cnt - a0, 32'd1);
    sample();
    chk1("wr_req_released", bus.bus_req_, 1'b1);
    chk32("wr_keeps_rd_buf", rd_data, 32'hDEADBEEF);
    next_cycle();

    // Read completing under stall: hold data in STALL, no relaunch
    bus_xfer(30'h10000004, 1'b1, 32'h0, 32'hDEADBEEF, 1, 2, 1'b1);
    as_ = 1'b0; addr = 30'h10000010;
    for (int i = 0; i < 3; i++) begin
      expect_ev(32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1);
      sample();
      next_cycle();
    end
    stall = 1'b0; as_ = 1'b1;
    sample();
    chk32("stall_release_rd_data", rd_data, 32'hDEADBEEF);
    next_cycle();

    // Flush in REQ before grant
    a0 = as_low_cnt;
    as_ = 1'b0; addr = 30'h10000020; rw = 1'b1;
    sample();
    chk1("flush_req_launch_busy", busy, 1'b1);
    next_cycle();
    flush = 1'b1; as_ = 1'b1;
    sample();
    chk1("flush_req_req_low", bus.bus_req_, 1'b0);
    next_cycle();
    flush = 1'b0; bus.bus_grnt_ = 1'b0;
    sample();
    chk1("flush_req_released", bus.bus_req_, 1'b1);
    next_cycle();
    bus.bus_grnt_ = 1'b1;
    sample();
    chk32("flush_req_no_strobe", as_low_cnt - a0, 32'd0);
    next_cycle();

    // Flush in ACCESS: cycle completes, data discarded, no STALL
    as_ = 1'b0; addr = 30'h10000030; rw = 1'b1;
    sample();
    next_cycle();
    bus.bus_grnt_ = 1'b0;
    sample();
    next_cycle();
    bus.bus_grnt_ = 1'b1; flush = 1'b1;
    sample();
    chk1("flush_acc_busy", busy, 1'b1);
    chk1("flush_acc_strobe", bus.bus_as_, 1'b0);
    next_cycle();
    flush = 1'b0; as_ = 1'b1; bus.bus_rdy_ = 1'b0; bus.bus_rd_data = 32'h55AA55AA; stall = 1'b1;
    sample();
    chk1("flush_acc_done_busy", busy, 1'b0);
    chk32("flush_acc_discard", rd_data, 32'hDEADBEEF);
    next_cycle();
    bus.bus_rdy_ = 1'b1; bus.bus_rd_data = 32'h0;

    // Relaunch right away proves IDLE; this access then times out
    as_ = 1'b0; addr = 30'h10000040; rw = 1'b1;
    sample();
    chk1("flush_acc_idle_relaunch", busy, 1'b1);
    next_cycle();
    stall = 1'b0; bus.bus_grnt_ = 1'b0;
    sample();
    chk1("tmo_req_low", bus.bus_req_, 1'b0);
    next_cycle();
    bus.bus_grnt_ = 1'b1;
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk1("tmo_waiting_busy", busy, 1'b1);
      next_cycle();
    end
    expect_ev(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    sample();
    next_cycle();
    as_ = 1'b1;
    expect_ev(32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    sample();
    next_cycle();
    sample();
    chk32("tmo_err_pulses", err_cnt - e0, 32'd1);
    chk32("tmo_rd_data_cleared", rd_data, 32'h0);
    chk1("tmo_req_released", bus.bus_req_, 1'b1);
    next_cycle();

    // Asynchronous reset in the middle of ACCESS
    as_ = 1'b0; addr = 30'h10000050; rw = 1'b0; wr_data = 32'h87654321;
    sample();
    next_cycle();
    bus.bus_grnt_ = 1'b0;
    sample();
    next_cycle();
    bus.bus_grnt_ = 1'b1;
    sample();
    chk1("mid_rst_in_access", bus.bus_as_, 1'b0);
    #1;
    reset = 1'b1; as_ = 1'b1;
    #1;
    chk1("mid_rst_bus_req_", bus.bus_req_, 1'b1);
    chk1("mid_rst_bus_as_", bus.bus_as_, 1'b1);
    chk1("mid_rst_bus_rw", bus.bus_rw, 1'b1);
    chk32("mid_rst_bus_addr", {2'b00, bus.bus_addr}, 32'h0);
    chk32("mid_rst_bus_wr_data", bus.bus_wr_data, 32'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    sample();
    chk1("post_rst_bus_req_", bus.bus_req_, 1'b1);

    chk32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
